uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among NREQ independent byte sources. It sits between the requesters and the `uart` wrapper's `tx_start` / `w_data` / `tx_done_tick` pins. It grants one requester at a time, launches the byte, and waits for the transmitter's completion tick before re-arbitrating. A watchdog aborts a grant if the completion tick never arrives.

## Interface
- NREQ, 4: number of requesters, 2..8.
- DBIT, 8: data byte width.
- TIMEOUT, 65535: clk cycles allowed in WAIT before abort; 0 disables the watchdog.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per source; held high with data stable until ack.
- data  in  NREQ*DBIT  byte of source i at data[i*DBIT +: DBIT].
- ack  out  NREQ  one-cycle pulse: byte of source i latched.
- done  out  NREQ  one-cycle pulse: byte of source i fully transmitted.
- err  out  NREQ  one-cycle pulse: grant of source i aborted by watchdog.
- tx_start  out  1  one-cycle launch pulse to transmitter.
- w_data  out  DBIT  byte to transmitter, stable from tx_start until next grant.
- tx_done_tick  in  1  completion pulse from transmitter.
- busy  out  1  high in START and WAIT.
- owner  out  clog2(NREQ)  index of current or last grant.

## Operation
- FSM states: IDLE, START, WAIT.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set:
  - Winner is the first set bit scanning upward from ptr, wrapping modulo NREQ.
  - Latch data[winner] into w_data and winner into owner.
  - Go to START.
- START:
  - ack[owner]=1 and tx_start=1 for exactly this cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- WAIT, tx_done_tick=1: done[owner] pulses next cycle, ptr ← (owner+1) mod NREQ, go to IDLE.
- WAIT, no tick, TIMEOUT≠0 and counter = TIMEOUT-1: err[owner] pulses next cycle, ptr advances as for done, go to IDLE.
- WAIT, otherwise: increment the counter, which saturates and never wraps.
- If tick and timeout coincide, the tick wins: done pulses, err does not.
- tx_done_tick in IDLE or START is ignored.
- A req still high after its ack counts as a new request. The source must update data in the cycle after ack.
- ptr guarantees fairness: with all requests held, grants go 0,1,…,NREQ-1,0,…
- req bits changing while in START or WAIT do not affect the current grant.
- At most one bit of ack/done/err is set in any cycle.
- ack, done and err are never set together in the same cycle.

## Timing
- All outputs are registered.
- Reset values (async assert, sync release):
  - state=IDLE, ptr=0, owner=0, w_data=0.
  - ack=done=err=0, tx_start=0, busy=0, counter=0.
- Reset mid-WAIT: the grant is dropped silently with no done or err. The transmitter is reset by the same reset.
- Latency:
  - req seen in IDLE at cycle N → ack/tx_start/busy at N+1.
  - tx_done_tick at cycle M → done at M+1, busy low at M+1.
  - Earliest next ack: M+2.
- Back-to-back throughput: 3 cycles of overhead per byte plus the transmitter frame time.
- Watchdog: err asserts TIMEOUT+1 cycles after tx_start when no tick arrives.

## Test plan
- Single byte:
  - Stimulus: req[2]=1, data[2]=0xA5, transmitter returns tick 20 cycles after tx_start.
  - Response: ack[2] and tx_start one cycle after req, w_data=0xA5, done[2] one cycle after tick, owner=2.
- Simultaneous requests:
  - Stimulus: req=4'b1010 at reset exit.
  - Response: source 1 granted first, then source 3. No cycle with two ack bits set.
- Fairness:
  - Stimulus: all four req held high for 8 grants, tick returned immediately each time.
  - Response: grant order 0,1,2,3,0,1,2,3; every done matches the prior ack index.
- Watchdog:
  - Stimulus: TIMEOUT=10, tick never returned for req[0].
  - Response: err[0] exactly 11 cycles after tx_start, done[0] never pulses, ptr moves to 1, busy drops with err.
- Reset and spurious tick:
  - Stimulus: tick pulsed in IDLE; later reset asserted mid-WAIT.
  - Response: spurious tick produces no done. Reset immediately clears busy, owner=0, no done/err. After release, req[3] is granted normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ byte sources.
// A watchdog abandons any grant whose transmitter completion tick never arrives.
module uart_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DBIT-1:0]    data,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         done,
    output logic [NREQ-1:0]         err,
    output logic                    tx_start,
    output logic [DBIT-1:0]         w_data,
    input  logic                    tx_done_tick,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic [1:0]              state_dbg
);
    localparam int OW = $clog2(NREQ);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [OW-1:0] LAST      = OW'(NREQ - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [OW-1:0]  ptr, ptr_n;
    logic [OW-1:0]  owner_n, winner, owner_inc;
    logic [DBIT-1:0] w_data_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [NREQ-1:0] ack_n, done_n, err_n;
    logic           tx_start_n, busy_n, found;

    assign state_dbg = state;
    assign owner_inc = (owner == LAST) ? '0 : owner + 1'b1;

    // First requesting source at or above ptr, wrapping around.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr) + i) % NREQ]) begin
                found  = 1'b1;
                winner = OW'((int'(ptr) + i) % NREQ);
            end
        end
    end

    // Handshake: a source raises req with its byte valid on data and holds both
    // until it sees its one-cycle ack; the byte is captured into w_data on the
    // same edge that raises ack, so the source may change data from then on.
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        owner_n    = owner;
        w_data_n   = w_data;
        cnt_n      = cnt;
        ack_n      = '0;
        done_n     = '0;
        err_n      = '0;
        tx_start_n = 1'b0;
        busy_n     = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n       = winner;
                    w_data_n      = data[int'(winner)*DBIT +: DBIT];
                    ack_n[winner] = 1'b1;
                    tx_start_n    = 1'b1;
                    busy_n        = 1'b1;
                    state_n       = START;
                end
            end
            START: begin
                cnt_n   = '0;
                busy_n  = 1'b1;
                state_n = WAIT;
            end
            WAIT: begin
                if (tx_done_tick) begin
                    done_n[owner] = 1'b1;
                    ptr_n         = owner_inc;
                    state_n       = IDLE;
                end else if (TIMEOUT != 0 && cnt == CNT_LIMIT) begin
                    err_n[owner] = 1'b1;
                    ptr_n        = owner_inc;
                    state_n      = IDLE;
                end else begin
                    busy_n = 1'b1;
                    if (cnt != '1) cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            w_data   <= '0;
            cnt      <= '0;
            ack      <= '0;
            done     <= '0;
            err      <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            w_data   <= w_data_n;
            cnt      <= cnt_n;
            ack      <= ack_n;
            done     <= done_n;
            err      <= err_n;
            tx_start <= tx_start_n;
            busy     <= busy_n;
        end
    end
endmodule
